// File: rtl/opp_link_pkg.sv
// Shared definitions for the opponent-tank UART link: receiver states, default header, B1 layout.
// Used by opp_frame_rx and opponent_link_ctl; OPP_LINK_CHECKSUM_EN selects the 5-byte framing.
package opp_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GOT_HDR,
        GOT_B1,
        GOT_B2,
        GOT_B3
    } rx_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // B1 = {2'b00, dir[1:0], x[9:8], y[9:8]}
    localparam int B1_DIR_LSB = 4;
    localparam int B1_X_LSB   = 2;
    localparam int B1_Y_LSB   = 0;

endpackage

// File: rtl/opp_frame_rx.sv
// Byte assembler for opponent frames: HEADER, B1, B2, B3 [, CHK] with an inter-byte timeout.
// Define OPP_LINK_CHECKSUM_EN to require a trailing CHK = B1^B2^B3 byte.
module opp_frame_rx
    import opp_link_pkg::*;
#(
    parameter logic [7:0] HEADER         = HEADER_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       good,
    output logic       frame_err,
    output logic [1:0] dir,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic [TW-1:0] gap_cnt;
    logic          timeout;
    logic [5:0]    b1;
    logic [7:0]    b2;
    logic [7:0]    y_lo;

    assign timeout = (state != IDLE) && !rx_valid && (gap_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_next;
            if (rx_valid || state == IDLE || timeout)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + TW'(1);
        end
    end

`ifdef OPP_LINK_CHECKSUM_EN
    logic [7:0] b3;
    logic [7:0] chk;

    always_ff @(posedge clk) begin
        if (rx_valid && state == GOT_B2)
            b3 <= rx_data;
    end

    assign y_lo = b3;
    assign chk  = {2'b00, b1} ^ b2 ^ b3;
`else
    // Without a checksum the frame completes on B3, so its y byte is taken straight off the bus.
    assign y_lo = rx_data;
`endif

    always_ff @(posedge clk) begin
        if (rx_valid) begin
            case (state)
                GOT_HDR: b1 <= rx_data[5:0];
                GOT_B1:  b2 <= rx_data;
                default: ;
            endcase
        end
    end

    assign dir = b1[B1_DIR_LSB +: 2];
    assign x   = {b1[B1_X_LSB +: 2], b2};
    assign y   = {b1[B1_Y_LSB +: 2], y_lo};

    // A HEADER value received mid-frame is ordinary data; only IDLE looks for it.
    always_comb begin
        state_next = state;
        good       = 1'b0;
        frame_err  = 1'b0;
        if (timeout) begin
            state_next = IDLE;
            frame_err  = 1'b1;
        end else if (rx_valid) begin
            case (state)
                IDLE:    if (rx_data == HEADER) state_next = GOT_HDR;
                GOT_HDR: state_next = GOT_B1;
                GOT_B1:  state_next = GOT_B2;
`ifdef OPP_LINK_CHECKSUM_EN
                GOT_B2:  state_next = GOT_B3;
                GOT_B3: begin
                    state_next = IDLE;
                    if (rx_data == chk) good = 1'b1;
                    else                frame_err = 1'b1;
                end
`else
                GOT_B2: begin
                    state_next = IDLE;
                    good       = 1'b1;
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/opponent_link_ctl.sv
// Opponent tank link: frames from opp_frame_rx are clipped, shadowed and committed on vsync rise.
// Optional OPP_LINK_CHECKSUM_EN (passed through to opp_frame_rx) adds a CHK byte per frame.
module opponent_link_ctl
    import opp_link_pkg::*;
#(
    parameter logic [7:0] HEADER           = HEADER_DEFAULT,
    parameter int         TIMEOUT_CYCLES   = 20000,
    parameter int         LINK_LOSS_FRAMES = 30,
    parameter logic [9:0] X_MAX            = 10'd960,
    parameter logic [9:0] Y_MAX            = 10'd704
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       vsync,
    output logic [9:0] Data_out_X,
    output logic [9:0] Data_out_Y,
    output logic [1:0] direction_tank,
    output logic       select_out,
    output logic [7:0] frame_err_cnt
);

    localparam int            LW        = $clog2(LINK_LOSS_FRAMES + 1);
    localparam logic [LW-1:0] LOSS_MAX  = LW'(LINK_LOSS_FRAMES);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LINK_LOSS_FRAMES - 1);

    function automatic logic [9:0] clip(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic          good;
    logic          frame_err;
    logic [1:0]    f_dir;
    logic [9:0]    f_x;
    logic [9:0]    f_y;
    logic          vsync_q;
    logic          commit;
    logic          pending;
    logic [9:0]    sh_x;
    logic [9:0]    sh_y;
    logic [1:0]    sh_dir;
    logic [LW-1:0] loss_cnt;

    opp_frame_rx #(
        .HEADER         (HEADER),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .good      (good),
        .frame_err (frame_err),
        .dir       (f_dir),
        .x         (f_x),
        .y         (f_y)
    );

    assign commit = vsync && !vsync_q;

    always_ff @(posedge clk) begin
        if (good) begin
            sh_x   <= clip(f_x, X_MAX);
            sh_y   <= clip(f_y, Y_MAX);
            sh_dir <= f_dir;
        end
    end

    // vsync_q resets high so a vsync already asserted at reset release is not a rise.
    // A frame finishing in the commit cycle stays pending; the commit uses the older shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q        <= 1'b1;
            pending        <= 1'b0;
            loss_cnt       <= '0;
            Data_out_X     <= '0;
            Data_out_Y     <= '0;
            direction_tank <= '0;
            select_out     <= 1'b0;
            frame_err_cnt  <= '0;
        end else begin
            vsync_q <= vsync;
            if (good)
                pending <= 1'b1;
            else if (commit)
                pending <= 1'b0;
            if (commit) begin
                if (pending) begin
                    Data_out_X     <= sh_x;
                    Data_out_Y     <= sh_y;
                    direction_tank <= sh_dir;
                    loss_cnt       <= '0;
                    select_out     <= 1'b1;
                end else begin
                    if (loss_cnt != LOSS_MAX)
                        loss_cnt <= loss_cnt + LW'(1);
                    if (loss_cnt >= LOSS_LAST)
                        select_out <= 1'b0;
                end
            end
            if (frame_err && frame_err_cnt != 8'hFF)
                frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_opponent_link_ctl.sv
// Scoreboard bench for opponent_link_ctl: a frame-level model predicts each vsync commit.
module tb_opponent_link_ctl;

    localparam int         TMO   = 100;
    localparam int         LLF   = 30;
    localparam logic [7:0] HDR   = 8'hA5;
    localparam logic [9:0] XMAX  = 10'd960;
    localparam logic [9:0] YMAX  = 10'd704;
`ifdef OPP_LINK_CHECKSUM_EN
    localparam int         NBYTES = 5;
`else
    localparam int         NBYTES = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       vsync;
    logic [9:0] Data_out_X;
    logic [9:0] Data_out_Y;
    logic [1:0] direction_tank;
    logic       select_out;
    logic [7:0] frame_err_cnt;

    always #5 clk = ~clk;

    opponent_link_ctl #(
        .HEADER           (HDR),
        .TIMEOUT_CYCLES   (TMO),
        .LINK_LOSS_FRAMES (LLF),
        .X_MAX            (XMAX),
        .Y_MAX            (YMAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .vsync          (vsync),
        .Data_out_X     (Data_out_X),
        .Data_out_Y     (Data_out_Y),
        .direction_tank (direction_tank),
        .select_out     (select_out),
        .frame_err_cnt  (frame_err_cnt)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic       sel;
        logic [7:0] err;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    logic [7:0] fbuf[$];
    int         gap;
    logic [9:0] m_x, m_y, s_x, s_y;
    logic [1:0] m_dir, s_dir;
    bit         m_sel, m_pend, m_vprev, vs_cur;
    int         m_err, miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fbuf.delete();
        gap = 0;
        m_x = '0; m_y = '0; m_dir = '0; m_sel = 0; m_err = 0;
        m_pend = 0; miss = 0; m_vprev = 1;
        s_x = '0; s_y = '0; s_dir = '0;
    endtask

    // One clock of stimulus; the model applies commit rules before frame completion.
    task automatic step(input bit v, input logic [7:0] d);
        bit         rise;
        bit         ok;
        logic [9:0] fx, fy;
        snap_t      s;
        rx_valid = v;
        rx_data  = d;
        vsync    = vs_cur;
        rise     = vs_cur && !m_vprev;
        m_vprev  = vs_cur;
        if (rise) begin
            if (m_pend) begin
                m_x = s_x; m_y = s_y; m_dir = s_dir;
                m_pend = 0; miss = 0; m_sel = 1;
            end else begin
                if (miss < LLF) miss++;
                if (miss == LLF) m_sel = 0;
            end
        end
        if (v) begin
            gap = 0;
            if (fbuf.size() != 0 || d == HDR) fbuf.push_back(d);
            if (fbuf.size() == NBYTES) begin
                ok = (NBYTES == 4) || (fbuf[NBYTES-1] == (fbuf[1] ^ fbuf[2] ^ fbuf[3]));
                if (ok) begin
                    fx = {fbuf[1][3:2], fbuf[2]};
                    fy = {fbuf[1][1:0], fbuf[3]};
                    s_x   = (fx > XMAX) ? XMAX : fx;
                    s_y   = (fy > YMAX) ? YMAX : fy;
                    s_dir = fbuf[1][5:4];
                    m_pend = 1;
                end else if (m_err < 255) begin
                    m_err++;
                end
                fbuf.delete();
            end
        end else if (fbuf.size() != 0) begin
            gap++;
            if (gap >= TMO) begin
                fbuf.delete();
                gap = 0;
                if (m_err < 255) m_err++;
            end
        end
        if (rise) begin
            s.x = m_x; s.y = m_y; s.dir = m_dir; s.sel = m_sel; s.err = 8'(m_err);
            exp_q.push_back(s);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    task automatic vpulse();
        vs_cur = 1; idle(2);
        vs_cur = 0; idle(2);
    endtask

    task automatic send_frame(input logic [1:0] dir, input logic [9:0] x, input logic [9:0] y,
                              input bit bad, input bit rise_last, input int maxgap);
        logic [7:0] b [5];
        b[0] = HDR;
        b[1] = {2'b00, dir, x[9:8], y[9:8]};
        b[2] = x[7:0];
        b[3] = y[7:0];
        b[4] = b[1] ^ b[2] ^ b[3] ^ {7'd0, bad};
        for (int i = 0; i < NBYTES; i++) begin
            if (i == NBYTES - 1 && rise_last) vs_cur = 1;
            step(1'b1, b[i]);
            if (i < NBYTES - 1 && maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        vsync = vs_cur;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_x",   32'(Data_out_X), 32'd0);
        check("rst_y",   32'(Data_out_Y), 32'd0);
        check("rst_dir", 32'(direction_tank), 32'd0);
        check("rst_sel", 32'(select_out), 32'd0);
        check("rst_err", 32'(frame_err_cnt), 32'd0);
        rst = 1'b0;
    endtask

    // Monitor: detects vsync rises independently and compares the committed outputs.
    initial begin
        bit    prev;
        bit    r;
        snap_t e;
        prev = 1;
        forever begin
            @(posedge clk);
            if (rst) begin
                prev = 1;
            end else begin
                r = vsync && !prev;
                prev = vsync;
                if (r) begin
                    #1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_unexpected: got a commit, expected none queued");
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_x",   32'(Data_out_X), 32'(e.x));
                        check("commit_y",   32'(Data_out_Y), 32'(e.y));
                        check("commit_dir", 32'(direction_tank), 32'(e.dir));
                        check("commit_sel", 32'(select_out), 32'(e.sel));
                        check("commit_err", 32'(frame_err_cnt), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; vsync = 1'b0; vs_cur = 0;
        do_reset();
        idle(3);

        // Reference frame and clip frame
        send_frame(2'd3, 10'd320, 10'd288, 0, 0, 0);
        vpulse();
        send_frame(2'd0, 10'd1000, 10'd750, 0, 0, 0);
        vpulse();
`ifdef OPP_LINK_CHECKSUM_EN
        send_frame(2'd1, 10'd5, 10'd6, 1, 0, 0);
        vpulse();
`endif

        // Inter-byte timeout, then a clean frame
        step(1'b1, HDR);
        step(1'b1, 8'h1D);
        idle(TMO + 5);
        send_frame(2'd2, 10'd100, 10'd200, 0, 0, 0);
        vpulse();

        // Link loss then recovery
        repeat (LLF + 2) vpulse();
        send_frame(2'd1, 10'd77, 10'd88, 0, 0, 0);
        vpulse();

        // Frame completing in the commit cycle
        send_frame(2'd1, 10'd11, 10'd22, 0, 0, 0);
        vpulse();
        send_frame(2'd2, 10'd33, 10'd44, 0, 0, 0);
        send_frame(2'd3, 10'd55, 10'd66, 0, 1, 0);
        idle(1);
        vs_cur = 0; idle(2);
        vpulse();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom % 4)
                0: repeat ($urandom_range(1, 3)) step(1'b1, ($urandom % 3 == 0) ? HDR : 8'($urandom));
                1: send_frame(2'($urandom), 10'($urandom), 10'($urandom),
                              ($urandom % 4) == 0, 0, 3);
                2: begin vs_cur = bit'($urandom % 2); idle($urandom_range(1, 4)); end
                default: vpulse();
            endcase
        end
        vs_cur = 0;
        idle(TMO + 2);
        vpulse();

        // Reset mid-frame with vsync high at release
        send_frame(2'd1, 10'd400, 10'd400, 0, 0, 0);
        vpulse();
        step(1'b1, HDR);
        step(1'b1, 8'h15);
        vs_cur = 1;
        do_reset();
        idle(3);
        step(1'b1, 8'h40);
        step(1'b1, 8'h20);
        vs_cur = 0; idle(2);
        send_frame(2'd2, 10'd123, 10'd456, 0, 0, 0);
        vpulse();

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            step(1'b1, HDR);
            idle(TMO);
        end
        vpulse();

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
